xc_malu_sequencer: RTL and testbench
====================================

// Module: xc_malu_sequencer
// PURPOSE
//  Initiator-side issue sequencer for xc_malu. Accepts one decoded multi-cycle
//  arithmetic request, drives the xc_malu uop/operand/modifier inputs with a
//  valid/ready handshake, splits two-step ops (msub/macc/mmul) into _1 then _2
//  uops, and returns a packed 64-bit result on a response handshake.
//  Sits between the execute-stage decode and the xc_malu instance.
// PARAMETERS
//  TIMEOUT  64  max cycles waiting on malu_ready per uop before abort (>=2)
//  CNT_W    7   width of timeout counter, must hold TIMEOUT
// PORTS
//  clock          in   1   system clock
//  resetn         in   1   synchronous active-low reset
//  req_valid      in   1   request valid
//  req_ready      out  1   sequencer can accept request
//  req_op         in   4   0 div,1 rem,2 mul,3 pmul,4 madd,5 msub,6 macc,7 mmul, 8-15 illegal
//  req_rs1/2/3    in   32  operands
//  req_lh_sign    in   1   rs1 signed
//  req_rh_sign    in   1   rs2 signed
//  req_carryless  in   1   carryless multiply
//  req_pw         in   5   one-hot {pw_2,pw_4,pw_8,pw_16,pw_32}
//  malu_valid     out  1   xc_malu valid
//  malu_flush     out  1   xc_malu flush
//  malu_rs1/2/3   out  32  xc_malu operands (held stable while malu_valid)
//  malu_uop_*     out  1   one-hot: div,rem,mul,pmul,madd,msub_1/2,macc_1/2,mmul_1/2
//  malu_lh_sign, malu_rh_sign, malu_carryless  out 1  modifiers
//  malu_pw_32/16/8/4/2  out  1  pack width
//  malu_result    in   64  xc_malu result
//  malu_ready     in   1   xc_malu result ready
//  rsp_valid      out  1   response valid
//  rsp_ready      in   1   response consumed
//  rsp_result     out  64  packed result
//  rsp_error      out  1   illegal op / bad pw / timeout
// BEHAVIOUR
//  - Reset (resetn=0 at posedge): state IDLE; malu_valid, malu_flush, all uop_*,
//    rsp_valid, rsp_error = 0; rsp_result, malu_rs* = 0; timeout counter = 0.
//  - req_ready = (state==IDLE). Request accepted on posedge with req_valid&&req_ready;
//    all request fields latched at that edge; unaccepted inputs ignored.
//  - FSM: IDLE -> S1 (legal) | RESP (illegal); S1 -> S2 (two-step) | RESP;
//    S2 -> RESP; RESP -> IDLE on rsp_valid&&rsp_ready.
//  - Legality: op<=7 AND req_pw one-hot AND (op!=3 || !pw_32) AND
//    (op==3 || pw_32). Else RESP with rsp_error=1, rsp_result=0, no malu issue.
//  - S1/S2: malu_valid=1 from cycle after entry; uop = single op, or x_1 in S1,
//    x_2 in S2. Operands/modifiers constant across S1 and S2.
//  - malu_flush = malu_valid && malu_ready (combinational). On that edge result
//    captured: S1 -> res1, S2 -> res2; malu_valid drops next cycle (one idle
//    cycle between S1 and S2 uops).
//  - Latency: accept at edge N -> malu_valid at N+1; rsp_valid 1 cycle after
//    final malu handshake. Minimum single-step: 3 cycles accept-to-rsp_valid.
//  - rsp_result: single-step = res1; two-step = {res2[31:0], res1[31:0]}.
//  - Timeout: counter clears on S1/S2 entry, increments each malu_valid&&!malu_ready
//    cycle; at count==TIMEOUT-1: malu_flush=1 for one cycle, malu_valid=0 next
//    cycle, go RESP with rsp_error=1, rsp_result=0.
//  - rsp_valid/rsp_result/rsp_error held stable until rsp_ready; no new request
//    accepted while RESP (no back-to-back bypass).
//  - Reset mid-operation: immediate return to reset values; in-flight malu op
//    abandoned (xc_malu sees valid=0 and its own reset).
// TESTING
//  1 mul, rs1=0xFFFFFFFF rs2=2 lh/rh signed -> one malu_uop_mul issue,
//    rsp_result=0xFFFFFFFF_FFFFFFFE, rsp_error=0.
//  2 macc, malu model returns 0x1111 then 0x2222 -> uops macc_1 then macc_2,
//    rsp_result=0x00002222_00001111.
//  3 req_op=9 -> no malu_valid ever, rsp_valid with rsp_error=1, result 0.
//  4 pmul with req_pw=5'b00011 -> rsp_error=1; pmul pw_8 legal -> malu_pw_8=1.
//  5 malu_ready never rises, TIMEOUT=64 -> flush pulse on 64th valid cycle,
//    rsp_error=1; req_ready=0 throughout.
//  6 rsp_ready held 0 for 10 cycles then 1 -> rsp held stable, req_ready=0 until
//    release; resetn=0 during S2 -> all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/xc_malu_sequencer_if.sv
// xc_malu_sequencer bus bundle: request, xc_malu issue and response channels.
// slave is the sequencer view, master the surrounding decode/malu/consumer view.
interface xc_malu_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [31:0] req_rs3;
    logic        req_lh_sign;
    logic        req_rh_sign;
    logic        req_carryless;
    logic [4:0]  req_pw;
    logic        malu_valid;
    logic        malu_flush;
    logic [31:0] malu_rs1;
    logic [31:0] malu_rs2;
    logic [31:0] malu_rs3;
    logic        malu_uop_div;
    logic        malu_uop_rem;
    logic        malu_uop_mul;
    logic        malu_uop_pmul;
    logic        malu_uop_madd;
    logic        malu_uop_msub_1;
    logic        malu_uop_msub_2;
    logic        malu_uop_macc_1;
    logic        malu_uop_macc_2;
    logic        malu_uop_mmul_1;
    logic        malu_uop_mmul_2;
    logic        malu_lh_sign;
    logic        malu_rh_sign;
    logic        malu_carryless;
    logic        malu_pw_32;
    logic        malu_pw_16;
    logic        malu_pw_8;
    logic        malu_pw_4;
    logic        malu_pw_2;
    logic [63:0] malu_result;
    logic        malu_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic        rsp_error;

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, req_rs3,
        input  req_lh_sign, req_rh_sign, req_carryless, req_pw,
        output req_ready,
        output malu_valid, malu_flush, malu_rs1, malu_rs2, malu_rs3,
        output malu_uop_div, malu_uop_rem, malu_uop_mul, malu_uop_pmul,
        output malu_uop_madd, malu_uop_msub_1, malu_uop_msub_2,
        output malu_uop_macc_1, malu_uop_macc_2,
        output malu_uop_mmul_1, malu_uop_mmul_2,
        output malu_lh_sign, malu_rh_sign, malu_carryless,
        output malu_pw_32, malu_pw_16, malu_pw_8, malu_pw_4, malu_pw_2,
        input  malu_result, malu_ready,
        output rsp_valid, rsp_result, rsp_error,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, req_rs3,
        output req_lh_sign, req_rh_sign, req_carryless, req_pw,
        input  req_ready,
        input  malu_valid, malu_flush, malu_rs1, malu_rs2, malu_rs3,
        input  malu_uop_div, malu_uop_rem, malu_uop_mul, malu_uop_pmul,
        input  malu_uop_madd, malu_uop_msub_1, malu_uop_msub_2,
        input  malu_uop_macc_1, malu_uop_macc_2,
        input  malu_uop_mmul_1, malu_uop_mmul_2,
        input  malu_lh_sign, malu_rh_sign, malu_carryless,
        input  malu_pw_32, malu_pw_16, malu_pw_8, malu_pw_4, malu_pw_2,
        output malu_result, malu_ready,
        input  rsp_valid, rsp_result, rsp_error,
        output rsp_ready
    );
endinterface

// File: rtl/xc_malu_sequencer.sv
// Issue sequencer for xc_malu: one request in, one or two uops out,
// packed 64-bit result back on a response handshake.
module xc_malu_sequencer #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic               clock,
    input  logic               resetn,
    xc_malu_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, S1, S2, RESP} state_t;

    state_t           state;
    state_t           state_nx;
    logic [3:0]       op_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      res1;
    logic [31:0]      rs1_q;
    logic [31:0]      rs2_q;
    logic [31:0]      rs3_q;
    logic             lh_q;
    logic             rh_q;
    logic             cl_q;
    logic [4:0]       pw_q;
    logic             rsp_valid_q;
    logic             rsp_error_q;
    logic [63:0]      rsp_result_q;

    logic accept;
    logic pw_onehot;
    logic legal;
    logic two_step;
    logic timeout;
    logic flush;
    logic issuing;

    assign accept    = bus.req_valid && (state == IDLE);
    assign pw_onehot = (bus.req_pw != 5'd0) &&
                       ((bus.req_pw & (bus.req_pw - 5'd1)) == 5'd0);
    // pmul needs a sub-word width; every other op runs at full 32-bit width
    assign legal     = (bus.req_op <= 4'd7) && pw_onehot &&
                       ((bus.req_op == 4'd3) ? !bus.req_pw[0] : bus.req_pw[0]);
    // only consulted while issuing, where op_q is known legal
    assign two_step  = (op_q >= 4'd5);
    assign timeout   = valid_q && !bus.malu_ready &&
                       (cnt == CNT_W'(TIMEOUT - 1));
    assign flush     = valid_q && (bus.malu_ready || timeout);
    assign issuing   = (state == S1) || (state == S2);

    // state register
    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // next-state: a timeout in S1 abandons the second uop
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = legal ? S1 : RESP;
            S1:   if (flush)  state_nx = (two_step && !timeout) ? S2 : RESP;
            S2:   if (flush)  state_nx = RESP;
            RESP: if (rsp_valid_q && bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // request latch, uop issue/capture and response registers
    always_ff @(posedge clock) begin
        if (!resetn) begin
            op_q         <= '0;
            valid_q      <= 1'b0;
            cnt          <= '0;
            res1         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rs3_q        <= '0;
            lh_q         <= 1'b0;
            rh_q         <= 1'b0;
            cl_q         <= 1'b0;
            pw_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_error_q  <= 1'b0;
            rsp_result_q <= '0;
        end else begin
            if (accept) begin
                op_q  <= bus.req_op;
                rs1_q <= bus.req_rs1;
                rs2_q <= bus.req_rs2;
                rs3_q <= bus.req_rs3;
                lh_q  <= bus.req_lh_sign;
                rh_q  <= bus.req_rh_sign;
                cl_q  <= bus.req_carryless;
                pw_q  <= bus.req_pw;
                if (!legal) begin
                    rsp_error_q  <= 1'b1;
                    rsp_result_q <= '0;
                end
            end
            if (issuing) begin
                if (!valid_q) begin
                    valid_q <= 1'b1;
                    cnt     <= '0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                    if (timeout) begin
                        rsp_error_q  <= 1'b1;
                        rsp_result_q <= '0;
                    end else if (state == S1) begin
                        res1 <= bus.malu_result[31:0];
                        if (!two_step) rsp_result_q <= bus.malu_result;
                    end else begin
                        rsp_result_q <= {bus.malu_result[31:0], res1};
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (state == RESP) begin
                if (!rsp_valid_q) begin
                    rsp_valid_q <= 1'b1;
                end else if (bus.rsp_ready) begin
                    rsp_valid_q  <= 1'b0;
                    rsp_error_q  <= 1'b0;
                    rsp_result_q <= '0;
                end
            end
        end
    end

    assign bus.req_ready       = (state == IDLE);
    assign bus.malu_valid      = valid_q;
    assign bus.malu_flush      = flush;
    assign bus.malu_rs1        = rs1_q;
    assign bus.malu_rs2        = rs2_q;
    assign bus.malu_rs3        = rs3_q;
    assign bus.malu_lh_sign    = lh_q;
    assign bus.malu_rh_sign    = rh_q;
    assign bus.malu_carryless  = cl_q;
    assign bus.malu_pw_2       = pw_q[4];
    assign bus.malu_pw_4       = pw_q[3];
    assign bus.malu_pw_8       = pw_q[2];
    assign bus.malu_pw_16      = pw_q[1];
    assign bus.malu_pw_32      = pw_q[0];
    assign bus.malu_uop_div    = valid_q && (op_q == 4'd0);
    assign bus.malu_uop_rem    = valid_q && (op_q == 4'd1);
    assign bus.malu_uop_mul    = valid_q && (op_q == 4'd2);
    assign bus.malu_uop_pmul   = valid_q && (op_q == 4'd3);
    assign bus.malu_uop_madd   = valid_q && (op_q == 4'd4);
    assign bus.malu_uop_msub_1 = valid_q && (op_q == 4'd5) && (state == S1);
    assign bus.malu_uop_msub_2 = valid_q && (op_q == 4'd5) && (state == S2);
    assign bus.malu_uop_macc_1 = valid_q && (op_q == 4'd6) && (state == S1);
    assign bus.malu_uop_macc_2 = valid_q && (op_q == 4'd6) && (state == S2);
    assign bus.malu_uop_mmul_1 = valid_q && (op_q == 4'd7) && (state == S1);
    assign bus.malu_uop_mmul_2 = valid_q && (op_q == 4'd7) && (state == S2);
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_result      = rsp_result_q;
    assign bus.rsp_error       = rsp_error_q;
endmodule

// File: tb/tb_xc_malu_sequencer.sv
// Bench for xc_malu_sequencer: transaction-level reference model,
// a malu responder and a per-cycle compare process.
module tb_xc_malu_sequencer;
    localparam int TIMEOUT = 64;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    xc_malu_sequencer_if bus ();

    xc_malu_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clock) cyc++;

    // reference transaction: expected uop list, delays, results, response
    logic        chk_en = 1'b0;
    logic        busy   = 1'b0;
    int          txn_id = 0;
    int          acc_cyc;
    int          exp_uops[$];
    int          dly[2];
    logic [63:0] resv[2];
    logic [63:0] e_res;
    logic        e_err;
    int          e_lat;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
    logic [31:0] e_rs3;
    logic [2:0]  e_mod;
    logic [4:0]  e_pw;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] uops();
        return {bus.malu_uop_mmul_2, bus.malu_uop_mmul_1,
                bus.malu_uop_macc_2, bus.malu_uop_macc_1,
                bus.malu_uop_msub_2, bus.malu_uop_msub_1,
                bus.malu_uop_madd, bus.malu_uop_pmul,
                bus.malu_uop_mul, bus.malu_uop_rem, bus.malu_uop_div};
    endfunction

    function automatic logic [4:0] pw_out();
        return {bus.malu_pw_2, bus.malu_pw_4, bus.malu_pw_8,
                bus.malu_pw_16, bus.malu_pw_32};
    endfunction

    // compare process + xc_malu responder
    int vk       = 0;
    int step     = 0;
    int seen_id  = -1;
    bit gap      = 1'b0;
    bit rsp_seen = 1'b0;
    always @(negedge clock) begin
        bit rdy;
        bit fl;
        if (!chk_en) begin
            bus.malu_ready  = 1'b0;
            bus.malu_result = '0;
        end else begin
            if (seen_id != txn_id) begin
                seen_id  = txn_id;
                vk       = 0;
                step     = 0;
                gap      = 1'b0;
                rsp_seen = 1'b0;
            end
            chk("req_ready", bus.req_ready, !busy);
            if (gap) chk("malu_valid_gap", bus.malu_valid, 0);
            gap = 1'b0;
            if (exp_uops.size() == 0 || !bus.malu_valid) begin
                if (exp_uops.size() == 0)
                    chk("malu_valid_idle", bus.malu_valid, 0);
                bus.malu_ready  = 1'($urandom_range(0, 1));
                bus.malu_result = {$urandom, $urandom};
                #1;
                chk("flush_idle", bus.malu_flush, 0);
            end else begin
                chk("uop", uops(), 64'(1) << exp_uops[0]);
                chk("malu_rs1", bus.malu_rs1, e_rs1);
                chk("malu_rs2", bus.malu_rs2, e_rs2);
                chk("malu_rs3", bus.malu_rs3, e_rs3);
                chk("malu_mods", {bus.malu_lh_sign, bus.malu_rh_sign,
                                  bus.malu_carryless}, e_mod);
                chk("malu_pw", pw_out(), e_pw);
                vk++;
                rdy = (vk == dly[step] + 1);
                bus.malu_ready  = rdy;
                bus.malu_result = rdy ? resv[step] : {$urandom, $urandom};
                #1;
                fl = rdy || (vk == TIMEOUT);
                chk("malu_flush", bus.malu_flush, fl);
                if (fl) begin
                    void'(exp_uops.pop_front());
                    if (!rdy) exp_uops.delete();
                    step++;
                    vk  = 0;
                    gap = 1'b1;
                end
            end
            if (busy && bus.rsp_valid) begin
                chk("rsp_result", bus.rsp_result, e_res);
                chk("rsp_error", bus.rsp_error, e_err);
                if (!rsp_seen) begin
                    rsp_seen = 1'b1;
                    chk("rsp_latency", cyc - acc_cyc, e_lat);
                end
            end else if (!busy) begin
                chk("rsp_valid_idle", bus.rsp_valid, 0);
            end
        end
    end

    // build the expectation, present the request, wait for acceptance
    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c,
                         input logic [2:0] mod, input logic [4:0] pw,
                         input int d1, input int d2,
                         input logic [63:0] r1, input logic [63:0] r2);
        bit lg;
        bit two;
        int ns;
        int o;
        o   = int'(op);
        lg  = (o <= 7) && ($countones(pw) == 1) &&
              ((o == 3) ? !pw[0] : pw[0]);
        two = lg && (o >= 5);
        ns  = !lg ? 0 : (two ? 2 : 1);
        exp_uops.delete();
        dly[0]  = d1;
        dly[1]  = d2;
        resv[0] = r1;
        resv[1] = r2;
        e_rs1   = a;
        e_rs2   = b;
        e_rs3   = c;
        e_mod   = mod;
        e_pw    = pw;
        e_err   = !lg;
        e_lat   = 1;
        for (int s = 0; s < ns; s++) begin
            exp_uops.push_back(two ? (2 * o - 5 + s) : o);
            if (dly[s] >= TIMEOUT) begin
                e_lat += TIMEOUT + 1;
                e_err  = 1'b1;
                break;
            end
            e_lat += dly[s] + 2;
        end
        if (e_err)    e_res = '0;
        else if (two) e_res = {r2[31:0], r1[31:0]};
        else          e_res = r1;
        txn_id++;
        bus.req_op        = op;
        bus.req_rs1       = a;
        bus.req_rs2       = b;
        bus.req_rs3       = c;
        {bus.req_lh_sign, bus.req_rh_sign, bus.req_carryless} = mod;
        bus.req_pw        = pw;
        bus.req_valid     = 1'b1;
        @(posedge clock);
        #1;
        acc_cyc = cyc;
        busy    = 1'b1;
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_op    = 4'($urandom);
        bus.req_rs1   = $urandom;
        bus.req_rs2   = $urandom;
        bus.req_rs3   = $urandom;
        bus.req_pw    = 5'($urandom);
        {bus.req_lh_sign, bus.req_rh_sign, bus.req_carryless} = 3'($urandom);
    endtask

    // wait for the response, hold it, then consume it
    task automatic complete(input int hold, output logic [63:0] res,
                            output logic err, output int lat);
        int n = 0;
        while (!bus.rsp_valid && n < 300) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("rsp_arrives", bus.rsp_valid, 1);
        res = bus.rsp_result;
        err = bus.rsp_error;
        lat = cyc - acc_cyc;
        repeat (hold) begin
            @(posedge clock);
            #1;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        busy = 1'b0;
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_malu_valid"}, bus.malu_valid, 0);
        chk({tag, "_malu_flush"}, bus.malu_flush, 0);
        chk({tag, "_uops"}, uops(), 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_error"}, bus.rsp_error, 0);
        chk({tag, "_rsp_result"}, bus.rsp_result, 0);
        chk({tag, "_malu_rs"}, {bus.malu_rs1, bus.malu_rs2}, 0);
        chk({tag, "_malu_rs3"}, bus.malu_rs3, 0);
        chk({tag, "_req_ready"}, bus.req_ready, 1);
    endtask

    initial begin
        logic [63:0] r;
        logic        e;
        int          l;
        int          n;
        resetn        = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_rs1   = '0;
        bus.req_rs2   = '0;
        bus.req_rs3   = '0;
        bus.req_pw    = '0;
        bus.req_lh_sign   = 1'b0;
        bus.req_rh_sign   = 1'b0;
        bus.req_carryless = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk_reset_outputs("reset");
        resetn = 1'b1;
        chk_en = 1'b1;
        @(posedge clock);
        #1;

        // signed mul -1 * 2
        issue(4'd2, 32'hFFFF_FFFF, 32'd2, 32'd0, 3'b110, 5'b00001,
              0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0);
        complete(0, r, e, l);
        chk("t1_result", r, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("t1_error", e, 0);
        chk("t1_latency", l, 3);

        // macc split into macc_1 / macc_2
        issue(4'd6, 32'h10, 32'h20, 32'h30, 3'b000, 5'b00001,
              1, 0, 64'h1111, 64'h2222);
        complete(1, r, e, l);
        chk("t2_result", r, 64'h0000_2222_0000_1111);
        chk("t2_error", e, 0);
        chk("t2_latency", l, 6);

        // illegal opcode
        issue(4'd9, 32'h1, 32'h2, 32'h3, 3'b000, 5'b00001, 0, 0, 64'd5, 64'd6);
        complete(2, r, e, l);
        chk("t3_error", e, 1);
        chk("t3_result", r, 0);

        // pmul with two pack widths set
        issue(4'd3, 32'h5, 32'h6, 32'h7, 3'b001, 5'b00011, 0, 0, 64'd1, 64'd2);
        complete(0, r, e, l);
        chk("t4a_error", e, 1);

        // pmul pw_8 legal
        issue(4'd3, 32'hA5A5, 32'h5A5A, 32'h0, 3'b001, 5'b00100,
              2, 0, 64'hDEAD_BEEF, 64'd0);
        @(posedge clock);
        #1;
        chk("t4b_valid_lat", bus.malu_valid, 1);
        chk("t4b_pw8", bus.malu_pw_8, 1);
        complete(0, r, e, l);
        chk("t4b_error", e, 0);
        chk("t4b_result", r, 64'hDEAD_BEEF);

        // malu_ready never arrives
        issue(4'd2, 32'h7, 32'h9, 32'h0, 3'b000, 5'b00001,
              1000, 0, 64'd0, 64'd0);
        complete(0, r, e, l);
        chk("t5_error", e, 1);
        chk("t5_result", r, 0);
        chk("t5_latency", l, TIMEOUT + 2);

        // response held off for 10 cycles
        issue(4'd7, 32'h1234, 32'h5678, 32'h9ABC, 3'b010, 5'b00001,
              2, 3, 64'hCAFE_0001_AAAA_0001, 64'hCAFE_0002_BBBB_0002);
        complete(10, r, e, l);
        chk("t6_result", r, 64'hBBBB_0002_AAAA_0001);

        // reset while the second uop is outstanding
        issue(4'd6, 32'h11, 32'h22, 32'h33, 3'b111, 5'b00001,
              0, 1000, 64'h7, 64'h8);
        n = 0;
        while (!bus.malu_uop_macc_2 && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("t6_in_s2", bus.malu_uop_macc_2, 1);
        chk_en        = 1'b0;
        bus.req_valid = 1'b0;
        resetn        = 1'b0;
        @(posedge clock);
        #1;
        chk_reset_outputs("midrst");
        resetn = 1'b1;
        busy   = 1'b0;
        exp_uops.delete();
        txn_id++;
        chk_en = 1'b1;
        @(posedge clock);
        #1;

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            logic [4:0] pw;
            op = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 3) != 0)
                pw = (op == 4'd3) ? 5'(1 << $urandom_range(1, 4)) : 5'b00001;
            else
                pw = 5'($urandom);
            issue(op, $urandom, $urandom, $urandom, 3'($urandom), pw,
                  $urandom_range(0, 4), $urandom_range(0, 4),
                  {$urandom, $urandom}, {$urandom, $urandom});
            complete($urandom_range(0, 3), r, e, l);
        end

        repeat (2) @(posedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
